hwpe_ctrl_ctx_sched: RTL and testbench
======================================

HWPE_CTRL_CTX_SCHED -- requirements
Module: hwpe_ctrl_ctx_sched

Interface
REQ-001 SHALL have parameter N_CONTEXT, default 2, number of job context slots (>=2).
REQ-002 SHALL have parameter N_CORES, default 16, number of requesting cores.
REQ-003 SHALL have derived parameters CW = max(1,$clog2(N_CONTEXT)) and IW = max(1,$clog2(N_CORES)).
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port acquire_i  in  1  core requests a free context.
REQ-007 SHALL have port acquire_core_i  in  IW  id of the requesting core.
REQ-008 SHALL have port acquire_ok_o  out  1  acquire granted, same cycle as acquire_i.
REQ-009 SHALL have port acquire_ctx_o  out  CW  context granted; equals alloc pointer.
REQ-010 SHALL have port trigger_i  in  1  core commits a context for execution.
REQ-011 SHALL have port trigger_ctx_i  in  CW  context being committed.
REQ-012 SHALL have port trigger_core_i  in  IW  id of the committing core.
REQ-013 SHALL have port start_o  out  1  one-cycle start pulse to the engine.
REQ-014 SHALL have port running_ctx_o  out  CW  context the engine must use.
REQ-015 SHALL have port engine_done_i  in  1  engine completion pulse.
REQ-016 SHALL have port evt_o  out  N_CORES  one-cycle completion event to the owner core.
REQ-017 SHALL have port err_o  out  1  one-cycle pulse on a rejected trigger.
REQ-018 SHALL have port busy_o  out  1  high while any slot is not FREE.
REQ-019 SHALL have port n_free_o  out  CW+1  number of FREE slots.

Function
REQ-020 SHALL hold per slot a state {FREE, ACQUIRED, QUEUED, RUNNING} and an owner id (IW bits).
REQ-021 SHALL keep alloc_ptr and run_ptr (CW bits each); each increments by 1 and wraps from N_CONTEXT-1 to 0.
REQ-022 acquire_ok_o SHALL be combinational: acquire_i && slot[alloc_ptr]==FREE, evaluated on registered state.
REQ-023 On a granted acquire, next edge SHALL set slot[alloc_ptr]=ACQUIRED, owner=acquire_core_i, and alloc_ptr+1.
REQ-024 Acquire with slot[alloc_ptr]!=FREE SHALL return acquire_ok_o=0 with no state change; no queuing of requests.
REQ-025 A trigger is accepted iff slot[trigger_ctx_i]==ACQUIRED and its owner==trigger_core_i; it then sets the slot to QUEUED at the next edge.
REQ-026 A rejected trigger SHALL leave state unchanged and assert err_o on the next cycle for one cycle.
REQ-027 The engine FSM SHALL have states IDLE, START, WAIT.
REQ-028 In IDLE with slot[run_ptr]==QUEUED, the FSM SHALL go to START; otherwise it stays in IDLE, even if other slots are QUEUED (strict ring order).
REQ-029 In START, start_o=1 for exactly one cycle and slot[run_ptr]=RUNNING; the FSM then goes to WAIT.
REQ-030 In WAIT, on engine_done_i the slot SHALL go FREE, evt_o[owner] pulses next cycle, run_ptr+1, and the FSM returns to IDLE.
REQ-031 engine_done_i outside WAIT SHALL be ignored.
REQ-032 Latency SHALL be: accepted trigger edge -> start_o 2 cycles later when the engine is idle; done -> evt_o 1 cycle.
REQ-033 running_ctx_o SHALL equal run_ptr at all times.
REQ-034 Acquire, trigger and done in the same cycle SHALL all take effect; a slot freed by done is not grantable until the next cycle.
REQ-035 busy_o and n_free_o SHALL be derived from registered slot states.

Reset
REQ-036 While rst_i is high at an edge, all slots SHALL go FREE with owners 0, both pointers 0, and the FSM to IDLE.
REQ-037 Reset SHALL give start_o=0, evt_o=0, err_o=0, busy_o=0, n_free_o=N_CONTEXT, acquire_ok_o=0.
REQ-038 Reset mid-job SHALL abort tracking with no evt_o emitted; later engine_done_i is ignored.

Verification
REQ-039 Core 3 acquires, then triggers ctx0 -> acquire_ok_o=1 with ctx 0; start_o 2 cycles after the trigger; done -> evt_o=16'h0008 next cycle; n_free_o back to 2.
REQ-040 Two acquires with no free slot, then a third acquire -> third gets acquire_ok_o=0; busy_o=1; n_free_o=0.
REQ-041 ctx1 triggered before ctx0 -> no start until ctx0 is triggered; start order is ctx0 then ctx1.
REQ-042 Core 5 triggers ctx owned by core 2, or triggers a FREE ctx -> err_o pulse; slot state unchanged.
REQ-043 Full with ctx0 running, done and acquire in the same cycle -> acquire_ok_o=0 that cycle; acquire succeeds the next cycle with ctx 0.
REQ-044 rst_i asserted in WAIT -> all outputs at reset values the next cycle; a following engine_done_i produces no evt_o.

Source files
------------

// File: rtl/hwpe_ctrl_ctx_sched.sv
// hwpe_ctrl_ctx_sched: ring-ordered job context scheduler for a shared HWPE engine.
// Cores acquire a slot, commit it with a trigger, and get a one-hot event when the engine finishes it.
module hwpe_ctrl_ctx_sched #(
    parameter int N_CONTEXT = 2,
    parameter int N_CORES   = 16,
    parameter int CW        = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
    parameter int IW        = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               acquire_i,
    input  logic [IW-1:0]      acquire_core_i,
    output logic               acquire_ok_o,
    output logic [CW-1:0]      acquire_ctx_o,
    input  logic               trigger_i,
    input  logic [CW-1:0]      trigger_ctx_i,
    input  logic [IW-1:0]      trigger_core_i,
    output logic               start_o,
    output logic [CW-1:0]      running_ctx_o,
    input  logic               engine_done_i,
    output logic [N_CORES-1:0] evt_o,
    output logic               err_o,
    output logic               busy_o,
    output logic [CW:0]        n_free_o
);

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_ACQUIRED = 2'd1,
        SLOT_QUEUED   = 2'd2,
        SLOT_RUNNING  = 2'd3
    } slot_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_START = 2'd1,
        ENG_WAIT  = 2'd2
    } eng_state_t;

    slot_state_t        slot_state_r [N_CONTEXT];
    slot_state_t        slot_state_s [N_CONTEXT];
    logic [IW-1:0]      owner_r [N_CONTEXT];
    logic [IW-1:0]      owner_s [N_CONTEXT];
    logic [CW-1:0]      alloc_ptr_r;
    logic [CW-1:0]      alloc_ptr_s;
    logic [CW-1:0]      run_ptr_r;
    logic [CW-1:0]      run_ptr_s;
    eng_state_t         eng_state_r;
    eng_state_t         eng_state_s;
    logic [N_CORES-1:0] evt_r;
    logic [N_CORES-1:0] evt_s;
    logic               err_r;
    logic               err_s;
    logic               grant_s;
    logic               trig_ok_s;
    logic               done_s;
    logic [CW:0]        n_free_s;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] ptr);
        if (ptr == CW'(N_CONTEXT - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = ptr + CW'(1);
        end
    endfunction

    // Grant is gated by reset so no acquire is reported while the block is being cleared
    assign grant_s = !rst_i && acquire_i && (slot_state_r[alloc_ptr_r] == SLOT_FREE);
    assign done_s  = engine_done_i && (eng_state_r == ENG_WAIT);

    // Trigger acceptance: slot must be held by the committing core
    always_comb begin
        trig_ok_s = 1'b0;
        if (trigger_i && (int'(trigger_ctx_i) < N_CONTEXT)) begin
            trig_ok_s = (slot_state_r[trigger_ctx_i] == SLOT_ACQUIRED) &&
                        (owner_r[trigger_ctx_i] == trigger_core_i);
        end else begin
            trig_ok_s = 1'b0;
        end
    end

    // Slot, pointer and pulse next-state; the updates always target distinct slots
    always_comb begin
        for (int i = 0; i < N_CONTEXT; i++) begin
            slot_state_s[i] = slot_state_r[i];
            owner_s[i]      = owner_r[i];
        end
        alloc_ptr_s = alloc_ptr_r;
        run_ptr_s   = run_ptr_r;
        evt_s       = '0;
        err_s       = trigger_i && !trig_ok_s;

        if (grant_s) begin
            slot_state_s[alloc_ptr_r] = SLOT_ACQUIRED;
            owner_s[alloc_ptr_r]      = acquire_core_i;
            alloc_ptr_s               = ptr_inc(alloc_ptr_r);
        end else begin
            alloc_ptr_s = alloc_ptr_r;
        end

        if (trig_ok_s) begin
            slot_state_s[trigger_ctx_i] = SLOT_QUEUED;
        end else begin
            err_s = trigger_i;
        end

        if (eng_state_r == ENG_START) begin
            slot_state_s[run_ptr_r] = SLOT_RUNNING;
        end else if (done_s) begin
            slot_state_s[run_ptr_r]   = SLOT_FREE;
            evt_s[owner_r[run_ptr_r]] = 1'b1;
            run_ptr_s                 = ptr_inc(run_ptr_r);
        end else begin
            run_ptr_s = run_ptr_r;
        end
    end

    // Engine FSM next state; only the slot under run_ptr may launch
    always_comb begin
        eng_state_s = eng_state_r;
        case (eng_state_r)
            ENG_IDLE: begin
                if (slot_state_r[run_ptr_r] == SLOT_QUEUED) begin
                    eng_state_s = ENG_START;
                end else begin
                    eng_state_s = ENG_IDLE;
                end
            end
            ENG_START: eng_state_s = ENG_WAIT;
            ENG_WAIT: begin
                if (engine_done_i) begin
                    eng_state_s = ENG_IDLE;
                end else begin
                    eng_state_s = ENG_WAIT;
                end
            end
            default: eng_state_s = ENG_IDLE;
        endcase
    end

    // Free-slot count from registered slot states
    always_comb begin
        n_free_s = '0;
        for (int i = 0; i < N_CONTEXT; i++) begin
            if (slot_state_r[i] == SLOT_FREE) begin
                n_free_s = n_free_s + (CW+1)'(1);
            end else begin
                n_free_s = n_free_s;
            end
        end
    end

    // State register: slots, pointers, engine FSM and pulsed outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                slot_state_r[i] <= SLOT_FREE;
                owner_r[i]      <= '0;
            end
            alloc_ptr_r <= '0;
            run_ptr_r   <= '0;
            eng_state_r <= ENG_IDLE;
            evt_r       <= '0;
            err_r       <= 1'b0;
        end else begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                slot_state_r[i] <= slot_state_s[i];
                owner_r[i]      <= owner_s[i];
            end
            alloc_ptr_r <= alloc_ptr_s;
            run_ptr_r   <= run_ptr_s;
            eng_state_r <= eng_state_s;
            evt_r       <= evt_s;
            err_r       <= err_s;
        end
    end

    assign acquire_ok_o  = grant_s;
    assign acquire_ctx_o = alloc_ptr_r;
    assign start_o       = (eng_state_r == ENG_START);
    assign running_ctx_o = run_ptr_r;
    assign evt_o         = evt_r;
    assign err_o         = err_r;
    assign n_free_o      = n_free_s;
    assign busy_o        = (n_free_s != (CW+1)'(N_CONTEXT));

endmodule

// File: tb/tb_hwpe_ctrl_ctx_sched.sv
// Scoreboard bench for hwpe_ctrl_ctx_sched: a slot-level reference model queues expected
// responses; a negedge monitor pops and compares them as the DUT presents outputs.
module tb_hwpe_ctrl_ctx_sched;

    localparam int N_CONTEXT = 2;
    localparam int N_CORES   = 16;
    localparam int CW        = 1;
    localparam int IW        = 4;

    localparam int S_FREE = 0, S_ACQ = 1, S_QUEUED = 2, S_RUN = 3;
    localparam int M_IDLE = 0, M_START = 1, M_WAIT = 2;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               acquire_i;
    logic [IW-1:0]      acquire_core_i;
    logic               acquire_ok_o;
    logic [CW-1:0]      acquire_ctx_o;
    logic               trigger_i;
    logic [CW-1:0]      trigger_ctx_i;
    logic [IW-1:0]      trigger_core_i;
    logic               start_o;
    logic [CW-1:0]      running_ctx_o;
    logic               engine_done_i;
    logic [N_CORES-1:0] evt_o;
    logic               err_o;
    logic               busy_o;
    logic [CW:0]        n_free_o;

    hwpe_ctrl_ctx_sched #(.N_CONTEXT(N_CONTEXT), .N_CORES(N_CORES)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .acquire_i      (acquire_i),
        .acquire_core_i (acquire_core_i),
        .acquire_ok_o   (acquire_ok_o),
        .acquire_ctx_o  (acquire_ctx_o),
        .trigger_i      (trigger_i),
        .trigger_ctx_i  (trigger_ctx_i),
        .trigger_core_i (trigger_core_i),
        .start_o        (start_o),
        .running_ctx_o  (running_ctx_o),
        .engine_done_i  (engine_done_i),
        .evt_o          (evt_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .n_free_o       (n_free_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
    } exp_t;

    exp_t st_q[$];
    exp_t gr_q[$];
    exp_t start_q[$];
    exp_t evt_q[$];
    exp_t err_q[$];

    int total = 0;
    int bad   = 0;

    // reference model: per-slot state/owner, ring pointers, engine phase
    int slot_m[N_CONTEXT];
    int owner_m[N_CONTEXT];
    int alloc_m;
    int run_m;
    int mode_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CONTEXT; i++) begin
            slot_m[i]  = S_FREE;
            owner_m[i] = 0;
        end
        alloc_m = 0;
        run_m   = 0;
        mode_m  = M_IDLE;
    endtask

    task automatic step(input int acq, input int acore, input int trg, input int tctx,
                        input int tcore, input int dn, input int rst);
        int  nfree;
        bit  g;
        bit  acc;
        @(posedge clk);
        #2;
        rst_i          = (rst != 0);
        acquire_i      = (acq != 0);
        acquire_core_i = IW'(acore);
        trigger_i      = (trg != 0);
        trigger_ctx_i  = CW'(tctx);
        trigger_core_i = IW'(tcore);
        engine_done_i  = (dn != 0);

        nfree = 0;
        for (int i = 0; i < N_CONTEXT; i++) if (slot_m[i] == S_FREE) nfree++;
        st_q.push_back('{cyc, (nfree != N_CONTEXT) ? 1 : 0, nfree, run_m});
        g = (rst == 0) && (acq != 0) && (slot_m[alloc_m] == S_FREE);
        if (acq != 0) gr_q.push_back('{cyc, g ? 1 : 0, alloc_m, 0});

        if (rst != 0) begin
            model_reset();
        end else begin
            acc = (trg != 0) && (slot_m[tctx] == S_ACQ) && (owner_m[tctx] == tcore);
            if (mode_m == M_IDLE && slot_m[run_m] == S_QUEUED) begin
                start_q.push_back('{cyc + 1, run_m, 0, 0});
                mode_m = M_START;
            end else if (mode_m == M_START) begin
                slot_m[run_m] = S_RUN;
                mode_m = M_WAIT;
            end else if (mode_m == M_WAIT && dn != 0) begin
                slot_m[run_m] = S_FREE;
                evt_q.push_back('{cyc + 1, 1 << owner_m[run_m], 0, 0});
                run_m  = (run_m + 1) % N_CONTEXT;
                mode_m = M_IDLE;
            end
            if (g) begin
                slot_m[alloc_m]  = S_ACQ;
                owner_m[alloc_m] = acore;
                alloc_m = (alloc_m + 1) % N_CONTEXT;
            end
            if (acc) slot_m[tctx] = S_QUEUED;
            else if (trg != 0) err_q.push_back('{cyc + 1, 1, 0, 0});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs against queued expectations at mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            e = st_q.pop_front();
            check("busy_o", 32'(busy_o), e.a);
            check("n_free_o", 32'(n_free_o), e.b);
            check("running_ctx_o", 32'(running_ctx_o), e.c);
        end
        if (acquire_i === 1'b1 && gr_q.size() > 0 && gr_q[0].cyc == cyc) begin
            e = gr_q.pop_front();
            check("acquire_ok_o", 32'(acquire_ok_o), e.a);
            if (e.a != 0) check("acquire_ctx_o", 32'(acquire_ctx_o), e.b);
        end
        if (start_q.size() > 0 && start_q[0].cyc == cyc) begin
            e = start_q.pop_front();
            check("start_o", 32'(start_o), 1);
            check("start_ctx", 32'(running_ctx_o), e.a);
        end else begin
            check("start_o_quiet", 32'(start_o), 0);
        end
        if (evt_q.size() > 0 && evt_q[0].cyc == cyc) begin
            e = evt_q.pop_front();
            check("evt_o", 32'(evt_o), e.a);
        end else begin
            check("evt_o_quiet", 32'(evt_o), 0);
        end
        if (err_q.size() > 0 && err_q[0].cyc == cyc) begin
            e = err_q.pop_front();
            check("err_o", 32'(err_o), 1);
        end else begin
            check("err_o_quiet", 32'(err_o), 0);
        end
    end

    initial begin
        int acq, trg, tctx, tcore;
        rst_i = 1'b1;
        acquire_i = 1'b0;
        acquire_core_i = '0;
        trigger_i = 1'b0;
        trigger_ctx_i = '0;
        trigger_core_i = '0;
        engine_done_i = 1'b0;
        model_reset();

        // reset held with an acquire pending: no grant
        step(1, 3, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // core 3 acquires ctx0, triggers, engine completes
        step(1, 3, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 3, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // fill both slots, reject third; out-of-order trigger and bad triggers
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 2, 0, 0);
        step(0, 0, 1, 0, 5, 0, 0);
        idle(3);
        step(0, 0, 1, 0, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1);
        step(0, 0, 1, 0, 5, 0, 0);
        idle(1);

        // full with ctx0 running: done and acquire together, then retry
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 7, 0, 0, 0, 0, 0);
        step(1, 8, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 7, 0, 0);
        idle(3);
        step(1, 9, 0, 0, 0, 1, 0);
        step(1, 9, 0, 0, 0, 0, 0);
        idle(1);

        // reset while the engine waits; stale done must not raise an event
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 3, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 3, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            acq  = ($urandom_range(0, 99) < 40) ? 1 : 0;
            trg  = ($urandom_range(0, 99) < 45) ? 1 : 0;
            tctx = $urandom_range(0, N_CONTEXT - 1);
            tcore = ($urandom_range(0, 3) != 0) ? owner_m[tctx] : $urandom_range(0, N_CORES - 1);
            step(acq, $urandom_range(0, N_CORES - 1), trg, tctx, tcore,
                 ($urandom_range(0, 99) < 30) ? 1 : 0,
                 ($urandom_range(0, 199) == 0) ? 1 : 0);
        end
        idle(8);
        @(negedge clk);
        @(negedge clk);

        total++;
        if ((st_q.size() + gr_q.size() + start_q.size() + evt_q.size() + err_q.size()) != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d/%0d/%0d/%0d/%0d want=0", st_q.size(), gr_q.size(),
                     start_q.size(), evt_q.size(), err_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
